// File: rtl/answer_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : answer_pkg
//  Description : Shared types and default sizing for the answer compare
//                engine (FSM state type, digit/level widths).
//  Revision    : 1.0  initial release
// ============================================================================
package answer_pkg;

  localparam int c_DIGIT_W    = 4;
  localparam int c_MAX_DIGITS = 7;
  localparam int c_LEVEL_W    = 4;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    CHECK   = 2'd2,
    RESULT  = 2'd3
  } state_t;

endpackage
`default_nettype wire

// File: rtl/answer_compare_engine_if.sv
`default_nettype none
// ============================================================================
//  Module      : answer_compare_engine_if
//  Description : Player/round signal bundle of the answer compare engine.
//                master = round controller / player side, slave = engine.
//  Revision    : 1.0  initial release
// ============================================================================
interface answer_compare_engine_if
  import answer_pkg::*;
#(
  parameter int DIGIT_W    = c_DIGIT_W,
  parameter int MAX_DIGITS = c_MAX_DIGITS,
  parameter int LEVEL_W    = c_LEVEL_W
);
  localparam int CNT_W = $clog2(MAX_DIGITS + 1);

  logic                          rng_button;
  logic                          auth_bit;
  logic                          logout;
  logic                          time_stop;
  logic                          punch_button;
  logic [DIGIT_W-1:0]            toggle_answer;
  logic [MAX_DIGITS*DIGIT_W-1:0] store_reg;
  logic [LEVEL_W-1:0]            level_num;
  logic                          win;
  logic                          loose;
  logic [DIGIT_W-1:0]            seg_in_ans;
  logic [CNT_W-1:0]              digit_cnt;
  logic                          busy;

  modport master (
    output rng_button, auth_bit, logout, time_stop, punch_button,
           toggle_answer, store_reg, level_num,
    input  win, loose, seg_in_ans, digit_cnt, busy
  );

  modport slave (
    input  rng_button, auth_bit, logout, time_stop, punch_button,
           toggle_answer, store_reg, level_num,
    output win, loose, seg_in_ans, digit_cnt, busy
  );

endinterface
`default_nettype wire

// File: rtl/digit_capture_buffer.sv
`default_nettype none
// ============================================================================
//  Module      : digit_capture_buffer
//  Description : MAX_DIGITS x DIGIT_W slot array with an auto-incrementing
//                write index. The index doubles as the committed-digit count.
//  Revision    : 1.0  initial release
// ============================================================================
module digit_capture_buffer #(
  parameter  int DIGIT_W    = 4,
  parameter  int MAX_DIGITS = 7,
  localparam int CNT_W      = $clog2(MAX_DIGITS + 1)
) (
  input  logic                          clock,
  input  logic                          rst,
  input  logic                          i_clear,
  input  logic                          i_wr_en,
  input  logic [DIGIT_W-1:0]            i_wr_data,
  output logic [CNT_W-1:0]              o_wr_idx,
  output logic [MAX_DIGITS*DIGIT_W-1:0] o_slots
);

  logic [CNT_W-1:0]   r_idx;
  logic [DIGIT_W-1:0] r_slot [MAX_DIGITS];

  // Slot storage and write pointer; a clear wins over a same-cycle write
  always_ff @(posedge clock or negedge rst) begin
    if (!rst) begin
      r_idx <= '0;
      for (int k = 0; k < MAX_DIGITS; k++) r_slot[k] <= '0;
    end else if (i_clear) begin
      r_idx <= '0;
      for (int k = 0; k < MAX_DIGITS; k++) r_slot[k] <= '0;
    end else if (i_wr_en) begin
      for (int k = 0; k < MAX_DIGITS; k++) begin
        if (r_idx == CNT_W'(k)) r_slot[k] <= i_wr_data;
      end
      r_idx <= r_idx + CNT_W'(1);
    end
  end

  assign o_wr_idx = r_idx;

  for (genvar g = 0; g < MAX_DIGITS; g++) begin : g_slot
    assign o_slots[g*DIGIT_W +: DIGIT_W] = r_slot[g];
  end

endmodule
`default_nettype wire

// File: rtl/answer_compare_engine.sv
`default_nettype none
// ============================================================================
//  Module      : answer_compare_engine
//  Description : Collects a round of punched digits and compares them with a
//                stored pattern, reporting win/loose. Optional build macro
//                ANSWER_EARLY_FAIL_EN ends the round on the first wrong digit.
//  Revision    : 1.0  initial release
// ============================================================================
module answer_compare_engine
  import answer_pkg::*;
#(
  parameter int DIGIT_W    = c_DIGIT_W,
  parameter int MAX_DIGITS = c_MAX_DIGITS,
  parameter int LEVEL_W    = c_LEVEL_W
) (
  input logic                    clock,
  input logic                    rst,
  answer_compare_engine_if.slave bus
);

  localparam int CNT_W = $clog2(MAX_DIGITS + 1);

  state_t                        r_state;
  logic                          r_win;
  logic                          r_loose;
  logic                          r_busy;
  logic [DIGIT_W-1:0]            r_seg;
  logic [CNT_W-1:0]              r_n_req;

  logic [LEVEL_W-1:0]            w_level;
  logic [CNT_W-1:0]              w_n_req_next;
  logic [CNT_W-1:0]              w_idx;
  logic [MAX_DIGITS*DIGIT_W-1:0] w_slots;
  logic                          w_start;
  logic                          w_wr;
  logic                          w_clear;
  logic                          w_last_punch;
  logic                          w_match;

  assign w_level      = bus.level_num;
  assign w_start      = ((r_state == IDLE) || (r_state == RESULT)) && bus.rng_button && bus.auth_bit;
  // A timer expiry in the same cycle as a punch swallows the punch
  assign w_wr         = !bus.logout && (r_state == COLLECT) && !bus.time_stop && bus.punch_button;
  assign w_clear      = bus.logout || w_start;
  assign w_last_punch = (w_idx + CNT_W'(1)) == r_n_req;

  digit_capture_buffer #(
    .DIGIT_W    (DIGIT_W),
    .MAX_DIGITS (MAX_DIGITS)
  ) u_buf (
    .clock     (clock),
    .rst       (rst),
    .i_clear   (w_clear),
    .i_wr_en   (w_wr),
    .i_wr_data (bus.toggle_answer),
    .o_wr_idx  (w_idx),
    .o_slots   (w_slots)
  );

  // Requested level clamped into 1..MAX_DIGITS
  always_comb begin
    w_n_req_next = CNT_W'(MAX_DIGITS);
    if (w_level == '0) begin
      w_n_req_next = CNT_W'(1);
    end else if (int'(w_level) < MAX_DIGITS) begin
      w_n_req_next = CNT_W'(w_level);
    end
  end

  // Compare only the first n_req slots against the pattern
  always_comb begin
    w_match = 1'b1;
    for (int k = 0; k < MAX_DIGITS; k++) begin
      if ((k < int'(r_n_req)) &&
          (w_slots[k*DIGIT_W +: DIGIT_W] != bus.store_reg[k*DIGIT_W +: DIGIT_W])) begin
        w_match = 1'b0;
      end
    end
  end

`ifdef ANSWER_EARLY_FAIL_EN
  logic [DIGIT_W-1:0] w_exp_digit;

  // Pattern digit expected at the current write position
  always_comb begin
    w_exp_digit = '0;
    for (int k = 0; k < MAX_DIGITS; k++) begin
      if (w_idx == CNT_W'(k)) w_exp_digit = bus.store_reg[k*DIGIT_W +: DIGIT_W];
    end
  end
`endif

  // Round FSM with registered outputs; logout overrides everything
  always_ff @(posedge clock or negedge rst) begin
    if (!rst) begin
      r_state <= IDLE;
      r_win   <= 1'b0;
      r_loose <= 1'b0;
      r_busy  <= 1'b0;
      r_seg   <= '0;
      r_n_req <= CNT_W'(1);
    end else if (bus.logout) begin
      r_state <= IDLE;
      r_win   <= 1'b0;
      r_loose <= 1'b0;
      r_busy  <= 1'b0;
      r_seg   <= '0;
    end else begin
      case (r_state)
        IDLE, RESULT: begin
          if (w_start) begin
            r_state <= COLLECT;
            r_win   <= 1'b0;
            r_loose <= 1'b0;
            r_busy  <= 1'b1;
            r_n_req <= w_n_req_next;
          end
        end
        COLLECT: begin
          if (bus.time_stop) begin
            r_state <= RESULT;
            r_win   <= 1'b0;
            r_loose <= 1'b1;
            r_busy  <= 1'b0;
          end else if (bus.punch_button) begin
            r_seg <= bus.toggle_answer;
`ifdef ANSWER_EARLY_FAIL_EN
            if (bus.toggle_answer != w_exp_digit) begin
              r_state <= RESULT;
              r_win   <= 1'b0;
              r_loose <= 1'b1;
              r_busy  <= 1'b0;
            end else
`endif
            if (w_last_punch) begin
              r_state <= CHECK;
            end
          end
        end
        CHECK: begin
          r_state <= RESULT;
          r_win   <= w_match;
          r_loose <= !w_match;
          r_busy  <= 1'b0;
        end
        default: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.win        = r_win;
  assign bus.loose      = r_loose;
  assign bus.busy       = r_busy;
  assign bus.seg_in_ans = r_seg;
  assign bus.digit_cnt  = w_idx;

endmodule
`default_nettype wire

// File: tb/tb_answer_compare_engine.sv
`default_nettype none
// ============================================================================
//  Module      : tb_answer_compare_engine
//  Description : Self-checking bench for answer_compare_engine. Observed
//                vector is {win, loose, busy, digit_cnt, seg_in_ans}.
//  Revision    : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
module tb_answer_compare_engine;

  localparam int DW = 4;
  localparam int MD = 7;
  localparam int LW = 4;
  localparam int CW = $clog2(MD + 1);
  localparam int OW = 3 + CW + DW;

  logic clock = 1'b0;
  logic rst   = 1'b0;
  int   total = 0;
  int   bad   = 0;
  int   exp_seg = 0;
  int   pat [MD];

  answer_compare_engine_if #(.DIGIT_W(DW), .MAX_DIGITS(MD), .LEVEL_W(LW)) bus ();

  answer_compare_engine #(.DIGIT_W(DW), .MAX_DIGITS(MD), .LEVEL_W(LW)) dut (
    .clock (clock),
    .rst   (rst),
    .bus   (bus.slave)
  );

  always #5 clock = ~clock;

  function automatic logic [OW-1:0] obs();
    return {bus.win, bus.loose, bus.busy, bus.digit_cnt, bus.seg_in_ans};
  endfunction

  function automatic logic [OW-1:0] ev(input logic w, input logic l, input logic b,
                                       input int c, input int s);
    return {w, l, b, CW'(c), DW'(s)};
  endfunction

  task automatic load_pattern();
    for (int k = 0; k < MD; k++) bus.store_reg[k*DW +: DW] = DW'(pat[k]);
  endtask

  task automatic start_round(input int lvl);
    bus.level_num  = LW'(lvl);
    bus.auth_bit   = 1'b1;
    bus.rng_button = 1'b1;
    @(negedge clock);
    bus.rng_button = 1'b0;
  endtask

  task automatic punch(input int d);
    bus.toggle_answer = DW'(d);
    bus.punch_button  = 1'b1;
    @(negedge clock);
    bus.punch_button  = 1'b0;
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clock);
    total++;
    if (obs() !== ev(0, 0, 0, 0, 0)) begin bad++; $display("FAIL reset_held: got %b want %b", obs(), ev(0,0,0,0,0)); end
    rst = 1'b1;
    @(negedge clock);
    total++;
    if (obs() !== ev(0, 0, 0, 0, 0)) begin bad++; $display("FAIL reset_release: got %b want %b", obs(), ev(0,0,0,0,0)); end
  endtask

  task automatic test_win();
    pat = '{3, 5, 9, 1, 2, 4, 6};
    load_pattern();
    start_round(3);
    total++;
    if (obs() !== ev(0, 0, 1, 0, 0)) begin bad++; $display("FAIL win_start: got %b want %b", obs(), ev(0,0,1,0,0)); end
    punch(3); punch(5); punch(9);
    exp_seg = 9;
    total++;
    if (obs() !== ev(0, 0, 1, 3, 9)) begin bad++; $display("FAIL win_t1: got %b want %b", obs(), ev(0,0,1,3,9)); end
    @(negedge clock);
    total++;
    if (obs() !== ev(1, 0, 0, 3, 9)) begin bad++; $display("FAIL win_t2: got %b want %b", obs(), ev(1,0,0,3,9)); end
  endtask

  task automatic test_lose();
    start_round(3);
    total++;
    if (obs() !== ev(0, 0, 1, 0, exp_seg)) begin bad++; $display("FAIL lose_start: got %b want %b", obs(), ev(0,0,1,0,exp_seg)); end
    punch(3); punch(5); punch(8);
    exp_seg = 8;
`ifdef ANSWER_EARLY_FAIL_EN
    total++;
    if (obs() !== ev(0, 1, 0, 3, 8)) begin bad++; $display("FAIL lose_early: got %b want %b", obs(), ev(0,1,0,3,8)); end
`else
    total++;
    if (obs() !== ev(0, 0, 1, 3, 8)) begin bad++; $display("FAIL lose_t1: got %b want %b", obs(), ev(0,0,1,3,8)); end
`endif
    @(negedge clock);
    total++;
    if (obs() !== ev(0, 1, 0, 3, 8)) begin bad++; $display("FAIL lose_t2: got %b want %b", obs(), ev(0,1,0,3,8)); end
  endtask

  task automatic test_timeout();
    start_round(3);
    punch(3);
    exp_seg = 3;
    bus.time_stop = 1'b1;
    @(negedge clock);
    bus.time_stop = 1'b0;
    total++;
    if (obs() !== ev(0, 1, 0, 1, 3)) begin bad++; $display("FAIL timeout: got %b want %b", obs(), ev(0,1,0,1,3)); end
    punch(5); punch(9);
    total++;
    if (obs() !== ev(0, 1, 0, 1, 3)) begin bad++; $display("FAIL timeout_hold: got %b want %b", obs(), ev(0,1,0,1,3)); end
    // timer expiry coincident with the final (correct) punch
    start_round(1);
    bus.time_stop = 1'b1;
    punch(3);
    bus.time_stop = 1'b0;
    total++;
    if (obs() !== ev(0, 1, 0, 0, 3)) begin bad++; $display("FAIL timeout_final: got %b want %b", obs(), ev(0,1,0,0,3)); end
  endtask

  task automatic test_levels();
    start_round(0);
    punch(pat[0]);
    exp_seg = pat[0];
    @(negedge clock);
    total++;
    if (obs() !== ev(1, 0, 0, 1, exp_seg)) begin bad++; $display("FAIL level0: got %b want %b", obs(), ev(1,0,0,1,exp_seg)); end
    start_round(12);
    for (int k = 0; k < 6; k++) punch(pat[k]);
    total++;
    if (obs() !== ev(0, 0, 1, 6, pat[5])) begin bad++; $display("FAIL level12_mid: got %b want %b", obs(), ev(0,0,1,6,pat[5])); end
    punch(pat[6]);
    exp_seg = pat[6];
    @(negedge clock);
    total++;
    if (obs() !== ev(1, 0, 0, 7, exp_seg)) begin bad++; $display("FAIL level12: got %b want %b", obs(), ev(1,0,0,7,exp_seg)); end
  endtask

  task automatic test_abort();
    start_round(5);
    punch(pat[0]); punch(pat[1]);
    bus.logout = 1'b1; bus.punch_button = 1'b1; bus.time_stop = 1'b1; bus.rng_button = 1'b1;
    @(negedge clock);
    bus.logout = 1'b0; bus.punch_button = 1'b0; bus.time_stop = 1'b0; bus.rng_button = 1'b0;
    exp_seg = 0;
    total++;
    if (obs() !== ev(0, 0, 0, 0, 0)) begin bad++; $display("FAIL logout: got %b want %b", obs(), ev(0,0,0,0,0)); end
    bus.auth_bit = 1'b0; bus.rng_button = 1'b1;
    @(negedge clock);
    bus.rng_button = 1'b0;
    @(negedge clock);
    total++;
    if (obs() !== ev(0, 0, 0, 0, 0)) begin bad++; $display("FAIL noauth: got %b want %b", obs(), ev(0,0,0,0,0)); end
    start_round(4);
    punch(pat[0]);
    #2 rst = 1'b0;
    #1;
    total++;
    if (obs() !== ev(0, 0, 0, 0, 0)) begin bad++; $display("FAIL rst_async: got %b want %b", obs(), ev(0,0,0,0,0)); end
    @(negedge clock);
    rst = 1'b1;
    @(negedge clock);
    exp_seg = 0;
  endtask

  task automatic test_random();
    int lvl, n, tmo, nc, d;
    bit lose, mism, done;
    for (int r = 0; r < 40; r++) begin
      for (int k = 0; k < MD; k++) pat[k] = int'($urandom_range(0, 15));
      load_pattern();
      lvl = int'($urandom_range(0, 15));
      n   = (lvl == 0) ? 1 : ((lvl > MD) ? MD : lvl);
      tmo = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, n - 1)) : -1;
      start_round(lvl);
      total++;
      if (obs() !== ev(0, 0, 1, 0, exp_seg)) begin bad++; $display("FAIL rnd_start r=%0d: got %b want %b", r, obs(), ev(0,0,1,0,exp_seg)); end
      bus.level_num = LW'($urandom_range(0, 15));
      nc = 0; lose = 0; mism = 0; done = 0;
      for (int i = 0; i < n && !done; i++) begin
        repeat ($urandom_range(0, 2)) begin
          bus.rng_button = 1'($urandom_range(0, 1));
          @(negedge clock);
        end
        bus.rng_button = 1'b0;
        d = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 15)) : pat[i];
        if (i == tmo) begin
          bus.time_stop     = 1'b1;
          bus.punch_button  = 1'($urandom_range(0, 1));
          bus.toggle_answer = DW'(d);
          @(negedge clock);
          bus.time_stop    = 1'b0;
          bus.punch_button = 1'b0;
          lose = 1; done = 1;
        end else begin
          punch(d);
          nc++;
          exp_seg = d;
          if (d != pat[i]) mism = 1;
`ifdef ANSWER_EARLY_FAIL_EN
          if (d != pat[i]) begin lose = 1; done = 1; end
`endif
        end
      end
      if (mism) lose = 1;
      repeat (2) begin
        bus.time_stop     = 1'($urandom_range(0, 1));
        bus.punch_button  = 1'($urandom_range(0, 1));
        bus.toggle_answer = DW'($urandom_range(0, 15));
        @(negedge clock);
      end
      bus.time_stop = 1'b0; bus.punch_button = 1'b0;
      total++;
      if (obs() !== ev(!lose, lose, 0, nc, exp_seg)) begin bad++; $display("FAIL rnd_result r=%0d: got %b want %b", r, obs(), ev(!lose,lose,0,nc,exp_seg)); end
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    bus.rng_button = 1'b0; bus.auth_bit = 1'b0; bus.logout = 1'b0; bus.time_stop = 1'b0;
    bus.punch_button = 1'b0; bus.toggle_answer = '0; bus.store_reg = '0; bus.level_num = '0;
    test_reset();
    test_win();
    test_lose();
    test_timeout();
    test_levels();
    test_abort();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
